// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline control and the multiply/divide unit.
// The master side issues operations and reads HI/LO; the slave side is the unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, funct, op1, op2, flush, input busy, done, hi, lo);
  modport slave  (input start, funct, op1, op2, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair: WIDTH-cycle
// shift-add multiply and restoring divide on magnitudes, single-cycle MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_div0;
  logic [WIDTH-1:0]   r_addend;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_is_mul_op;
  logic               w_is_div_op;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_idle_start;
  logic               w_accept;
  logic               w_finish;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_mul_op  = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign w_is_div_op  = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign w_signed     = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign w_a_neg      = w_signed & bus.op1[WIDTH-1];
  assign w_b_neg      = w_signed & bus.op2[WIDTH-1];
  // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign w_mag_a      = w_a_neg ? -bus.op1 : bus.op1;
  assign w_mag_b      = w_b_neg ? -bus.op2 : bus.op2;
  assign w_idle_start = (r_state == S_IDLE) && bus.start && !bus.flush;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  // Divide:   r_acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_addend} : '0);
    w_shifted = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, r_addend};
    if (!r_is_div)
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    else if (w_diff[WIDTH])
      w_acc_next = {w_shifted[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    else
      w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  assign w_prod = r_neg_lo ? -w_acc_next : w_acc_next;
  assign w_quo  = w_acc_next[WIDTH-1:0];
  assign w_rem  = w_acc_next[2*WIDTH-1:WIDTH];

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_idle_start && (w_is_mul_op || w_is_div_op)) begin
          w_next_state = S_RUN;
          w_accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_addend <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;

      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= w_is_div_op;
        r_neg_lo <= w_a_neg ^ w_b_neg;
        r_neg_hi <= w_a_neg;
        r_div0   <= w_is_div_op && (bus.op2 == '0);
        r_addend <= w_is_div_op ? w_mag_b : w_mag_a;
        r_acc    <= {{WIDTH{1'b0}}, (w_is_div_op ? w_mag_a : w_mag_b)};
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_acc_next;
      end

      // Divide-by-zero keeps the natural remainder (the raw dividend) but forces LO to all ones.
      if (w_finish) begin
        if (r_is_div) begin
          r_hi <= r_neg_hi ? -w_rem : w_rem;
          r_lo <= r_div0 ? '1 : (r_neg_lo ? -w_quo : w_quo);
        end else begin
          {r_hi, r_lo} <= w_prod;
        end
      end else if (w_idle_start && (bus.funct == F_MTHI)) begin
        r_hi <= bus.op1;
      end else if (w_idle_start && (bus.funct == F_MTLO)) begin
        r_lo <= bus.op1;
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that runs beside the combinational datapath ALU and owns the architectural HI/LO register pair.
- Executes MIPS MULT/MULTU/DIV/DIVU over WIDTH cycles, and MTHI/MTLO in a single cycle.
- Uses a start/busy/done handshake so the pipeline control can stall on HI/LO hazards.
- Parametrised in operand width; the single-cycle ALU has no sequential or wide-result capability, and this block supplies it.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- funct  in  6  MIPS funct code: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x11 mthi, 0x13 mtlo; others ignored
- op1  in  WIDTH  rs operand (multiplicand/dividend; value for mthi/mtlo)
- op2  in  WIDTH  rt operand (multiplier/divisor)
- flush  in  1  synchronous cancel of an in-flight operation
- busy  out  1  high while a mult/div is iterating
- done  out  1  one-cycle pulse; HI/LO updated on the same edge
- hi  out  WIDTH  HI register (mfhi reads this directly)
- lo  out  WIDTH  LO register (mflo reads this directly)

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0, internal datapath registers=0.
- Reset asserted mid-operation aborts the operation immediately; no partial result is visible.
- States are IDLE and RUN.
- IDLE:
  - start=1 with mthi or mtlo: hi or lo takes op1 on that edge. busy stays 0; done stays 0.
  - start=1 with mult/multu/div/divu: latch the operands, the signedness and the op kind; counter=0; go to RUN; busy=1 from the next cycle.
  - Any other funct: ignored.
- RUN: one iteration per edge, counter increments each edge.
  - Multiply: radix-2 shift-add on magnitudes, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract on magnitudes; WIDTH-bit remainder plus 1 guard bit; WIDTH-bit quotient.
  - On the edge that completes iteration WIDTH: apply sign correction, write hi/lo, done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: accept edge E0; result on edge E_WIDTH (32 cycles at default). busy is high for WIDTH cycles. A new start is accepted in the cycle done is high.
- Signed sign rules:
  - Product is negated if op1 and op2 signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitude of the most-negative value is 2^(WIDTH-1) unsigned.
- Result placement: mult puts the upper WIDTH bits in hi and the lower in lo. div puts the remainder in hi and the quotient in lo.
- Divide by zero: runs the full WIDTH cycles; result lo = all ones, hi = op1 (raw dividend), for both signed and unsigned. Never hangs.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
- start while busy=1: ignored for every funct, including mthi/mtlo. Upstream stalls.
- flush=1:
  - In RUN: return to IDLE next edge; busy=0; done=0; hi/lo unchanged.
  - Coinciding with the final-iteration edge: flush wins and there is no write.
  - In IDLE: flush wins over a simultaneous start.
- Operands are sampled only at accept; op1/op2 changes during RUN have no effect.
- All arithmetic is modulo 2^WIDTH per half; there are no exceptions and no overflow flag.

Test Plan:
- Signed mult, op1=7, op2=0xFFFFFFFD (-3) -> busy high 32 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat as multu with op1=op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed div, op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu, op1=100, op2=7 -> lo=14, hi=2.
- Divide by zero, div op1=0x12345678, op2=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x12345678.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi op1=0xA5A5A5A5, then mtlo op1=0x5A5A5A5A -> hi/lo update one cycle each; busy never asserts.
  - mtlo issued while a mult is busy -> ignored; lo holds the mult result after done.
- Control hazards:
  - flush at cycle 10 of a mult -> busy drops next edge, no done, hi/lo keep prior values.
  - rst_n pulsed low mid-div (asynchronously, between edges) -> busy/done/hi/lo=0 immediately.
  - Back-to-back: start in the done cycle is accepted and finishes 32 cycles later.
- Run all of the above at WIDTH=8, checked against a reference model with random operands, including 0x80 and 0x7F.
